// File: rtl/adder_pipelined_nbit.sv
// rtl/adder_pipelined_nbit.sv - pipelined N-bit adder, one slice per stage, valid/ready handshake
module adder_pipelined_nbit #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    input  logic             i_signed,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry,
    output logic             o_overflow
);

    localparam int S = (STAGES > 0) ? WIDTH / STAGES : 1;

    if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
        $fatal(1, "adder_pipelined_nbit: STAGES must be 1..WIDTH and divide WIDTH");
    end

    logic w_en;
    assign w_en    = i_ready | ~o_valid;
    assign o_ready = w_en;

    // r_acc holds finished sum slices below the current slice and untouched A bits above it,
    // so one WIDTH-wide register carries both; B shrinks as its slices are consumed.
    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int BW = WIDTH - k * S;

        logic [WIDTH-1:0] w_acc;
        logic [WIDTH-1:0] w_acc_nxt;
        logic [BW-1:0]    w_b;
        logic             w_c;
        logic             w_m;
        logic             w_v;
        logic [S:0]       w_add;

        logic             r_v;
        logic             r_c;
        logic [WIDTH-1:0] r_acc;

        if (k == 0) begin : g_in
            assign w_acc = i_a;
            assign w_b   = i_b;
            assign w_c   = i_cin;
            assign w_m   = i_signed;
            assign w_v   = i_valid;
        end else begin : g_in
            assign w_acc = g_stg[k-1].r_acc;
            assign w_b   = g_stg[k-1].g_fwd.r_b;
            assign w_c   = g_stg[k-1].r_c;
            assign w_m   = g_stg[k-1].g_fwd.r_m;
            assign w_v   = g_stg[k-1].r_v;
        end

        assign w_add = {1'b0, w_acc[k*S +: S]} + {1'b0, w_b[S-1:0]} + {{S{1'b0}}, w_c};

        always_comb begin
            w_acc_nxt            = w_acc;
            w_acc_nxt[k*S +: S]  = w_add[S-1:0];
        end

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_v   <= 1'b0;
                r_c   <= 1'b0;
                r_acc <= '0;
            end else if (w_en) begin
                r_v   <= w_v;
                r_c   <= w_add[S];
                r_acc <= w_acc_nxt;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [BW-S-1:0] r_b;
            logic            r_m;

            always_ff @(posedge i_clk) begin
                if (w_en) begin
                    r_b <= w_b[BW-1:S];
                    r_m <= w_m;
                end
            end
        end else begin : g_last
            logic r_ovf;

            // In the last stage w_acc[WIDTH-1] is still A's sign and w_b[S-1] is B's sign.
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_ovf <= 1'b0;
                end else if (w_en) begin
                    r_ovf <= w_m ? ((w_acc[WIDTH-1] == w_b[S-1]) && (w_add[S-1] != w_acc[WIDTH-1]))
                                 : w_add[S];
                end
            end
        end
    end

    assign o_valid    = g_stg[STAGES-1].r_v;
    assign o_sum      = g_stg[STAGES-1].r_acc;
    assign o_carry    = g_stg[STAGES-1].r_c;
    assign o_overflow = g_stg[STAGES-1].g_last.r_ovf;

endmodule
